// File: rtl/inst_fetch_responder.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_responder
//  Purpose  : Instruction-memory responder for the core fetch path; one request
//             in flight, fixed-latency valid/ready response, side loader port.
//  Revision : 1.0  initial release
// ============================================================================
module inst_fetch_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_inst,
    output logic        rsp_err,
    input  logic        ld_wen,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic [31:0] fetch_cnt
);

    localparam int unsigned c_DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [32:0] c_SPAN   = 33'd4 << DEPTH_LOG2;
    localparam logic [3:0]  c_LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_inst_q;
    logic [31:0] fetch_cnt_q;
    logic [31:0] mem_q [0:c_DEPTH-1];

    logic [31:0]           w_req_off;
    logic [31:0]           w_ld_off;
    logic                  w_req_err;
    logic                  w_ld_ok;
    logic [DEPTH_LOG2-1:0] w_req_idx;
    logic [DEPTH_LOG2-1:0] w_ld_idx;
    logic                  w_accept;
    logic                  w_handshake;

    // Offsets are unsigned 32-bit; addresses below the base wrap to huge values
    // and are also rejected by the explicit below-base compare.
    assign w_req_off = req_addr - BASE_ADDR;
    assign w_ld_off  = ld_addr - BASE_ADDR;
    assign w_req_err = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                       ({1'b0, w_req_off} >= c_SPAN);
    assign w_ld_ok   = (ld_addr >= BASE_ADDR) && ({1'b0, w_ld_off} >= 33'd0) &&
                       ({1'b0, w_ld_off} < c_SPAN);
    assign w_req_idx = w_req_off[DEPTH_LOG2+1:2];
    assign w_ld_idx  = w_ld_off[DEPTH_LOG2+1:2];

    assign req_ready   = !rst && ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));
    assign w_accept    = req_valid && req_ready;
    assign w_handshake = rsp_valid_q && rsp_ready;

    always_ff @(posedge clk) begin
        if (ld_wen && w_ld_ok) begin
            mem_q[w_ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_inst_q  <= 32'd0;
            fetch_cnt_q <= 32'd0;
        end else begin
            if (w_handshake) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            case (state_q)
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready && !req_valid) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
            // Accept overrides the RESP exit above; the mem read sees pre-write data.
            if (w_accept) begin
                rsp_inst_q <= w_req_err ? 32'd0 : mem_q[w_req_idx];
                rsp_err_q  <= w_req_err;
                if (LATENCY > 1) begin
                    state_q     <= S_WAIT;
                    cnt_q       <= c_LAT_M1;
                    rsp_valid_q <= 1'b0;
                end else begin
                    state_q     <= S_RESP;
                    cnt_q       <= 4'd0;
                    rsp_valid_q <= 1'b1;
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_inst  = rsp_inst_q;
    assign rsp_err   = rsp_err_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_responder.sv
`default_nettype none
// Bench for inst_fetch_responder: vector table, directed corner sequences and
// a randomized run against a transaction-level reference model.
module tb_inst_fetch_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          LAT0 = 2;
    localparam int          LAT1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][31:0] req_addr;
    logic             ld_wen;
    logic [31:0]      ld_addr;
    logic [31:0]      ld_data;

    logic        rdy0, rdy1, vld0, vld1, err0, err1;
    logic [31:0] inst0, inst1, cnt0, cnt1;

    logic [1:0]       req_ready_v, rsp_valid_v, rsp_err_v;
    logic [1:0][31:0] rsp_inst_v, fetch_cnt_v;
    assign req_ready_v = {rdy1, rdy0};
    assign rsp_valid_v = {vld1, vld0};
    assign rsp_err_v   = {err1, err0};
    assign rsp_inst_v  = {inst1, inst0};
    assign fetch_cnt_v = {cnt1, cnt0};

    inst_fetch_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(10), .LATENCY(LAT0)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(rdy0), .req_addr(req_addr[0]),
        .rsp_valid(vld0), .rsp_ready(rsp_ready[0]), .rsp_inst(inst0), .rsp_err(err0),
        .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_cnt(cnt0)
    );

    inst_fetch_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(10), .LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(rdy1), .req_addr(req_addr[1]),
        .rsp_valid(vld1), .rsp_ready(rsp_ready[1]), .rsp_inst(inst1), .rsp_err(err1),
        .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_cnt(cnt1)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mem_m [0:1023];
    logic [31:0] fcnt_e [2];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        err;
        string       name;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        off = a - BASE;
        if (a >= BASE && off < 32'h1000) mem_m[off[11:2]] = d;
    endtask

    function automatic logic mdl_err(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a % 4 != 0) || (a < BASE) || (off >= 32'h1000);
    endfunction

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_wen = 1'b1; ld_addr = a; ld_data = d;
        mdl_write(a, d);
        step();
        ld_wen = 1'b0;
    endtask

    // One complete request/response on instance sel, optionally with a
    // loader write in the accept cycle.
    task automatic fetch(input int sel, input logic [31:0] a, input logic [31:0] exp_inst,
                         input logic exp_err, input string name,
                         input bit with_ld, input logic [31:0] la, input logic [31:0] ldv);
        int n;
        req_valid[sel] = 1'b1; req_addr[sel] = a; rsp_ready[sel] = 1'b0;
        if (with_ld) begin
            ld_wen = 1'b1; ld_addr = la; ld_data = ldv;
            mdl_write(la, ldv);
        end
        #1;
        check({name, " req_ready"}, 32'(req_ready_v[sel]), 32'd1);
        step();
        req_valid[sel] = 1'b0; ld_wen = 1'b0;
        n = 1;
        while (rsp_valid_v[sel] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({name, " latency"}, 32'(n), 32'(sel == 0 ? LAT0 : LAT1));
        check({name, " inst"}, rsp_inst_v[sel], exp_inst);
        check({name, " err"}, 32'(rsp_err_v[sel]), 32'(exp_err));
        rsp_ready[sel] = 1'b1;
        step();
        rsp_ready[sel] = 1'b0;
        fcnt_e[sel] = fcnt_e[sel] + 32'd1;
        check({name, " fetch_cnt"}, fetch_cnt_v[sel], fcnt_e[sel]);
        check({name, " valid_drop"}, 32'(rsp_valid_v[sel]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        pend, e_err, exp_v, exp_rdy;
        logic [31:0] e_inst;
        int          due, cyc, r;

        vecs[0] = '{BASE,          32'h0010_0073, 1'b0, "basic"};
        vecs[1] = '{BASE + 32'd2,  32'h0,         1'b1, "misaligned"};
        vecs[2] = '{32'h7FFF_FFFC, 32'h0,         1'b1, "below_base"};
        vecs[3] = '{32'h8000_1000, 32'h0,         1'b1, "past_end"};
        vecs[4] = '{32'h8000_0FFC, 32'h5A5A_5A5A, 1'b0, "last_word"};
        vecs[5] = '{BASE + 32'd4,  32'h2222_2222, 1'b0, "ld_lowbits"};
        vecs[6] = '{32'hFFFF_FFFC, 32'h0,         1'b1, "top_addr"};
        vecs[7] = '{BASE + 32'd1,  32'h0,         1'b1, "misaligned1"};

        rst = 1'b1; req_valid = '0; rsp_ready = '0; req_addr = '0;
        ld_wen = 1'b0; ld_addr = '0; ld_data = '0;
        fcnt_e[0] = 0; fcnt_e[1] = 0;
        step();
        load(BASE, 32'h0010_0073);
        check("reset req_ready", 32'(req_ready_v), 32'd0);
        rst = 1'b0;
        #1;
        check("reset rsp_valid", 32'(rsp_valid_v), 32'd0);
        check("reset rsp_err", 32'(rsp_err_v), 32'd0);
        check("reset rsp_inst", rsp_inst_v[0], 32'd0);
        check("reset fetch_cnt", fetch_cnt_v[0], 32'd0);
        check("post-reset req_ready", 32'(req_ready_v), 32'd3);

        load(32'h8000_0FFC, 32'h5A5A_5A5A);
        load(32'h7FFF_FFFC, 32'hBADB_AD00);
        load(32'h8000_1000, 32'hBAD0_BAD0);
        load(32'h8000_0006, 32'h2222_2222);

        for (int i = 0; i < 8; i++) begin
            fetch(0, vecs[i].addr, vecs[i].inst, vecs[i].err, vecs[i].name, 1'b0, '0, '0);
        end

        // Back-to-back with continuous rsp_ready: one response every 2 cycles.
        load(BASE, 32'h1111_1111);
        load(BASE + 32'd4, 32'h2222_2222);
        load(BASE + 32'd8, 32'h3333_3333);
        req_valid[0] = 1'b1; req_addr[0] = BASE; rsp_ready[0] = 1'b1;
        step();
        req_addr[0] = BASE + 32'd4;
        step();
        check("b2b r0 valid", 32'(rsp_valid_v[0]), 32'd1);
        check("b2b r0 inst", rsp_inst_v[0], 32'h1111_1111);
        step();
        req_addr[0] = BASE + 32'd8;
        check("b2b gap0", 32'(rsp_valid_v[0]), 32'd0);
        step();
        check("b2b r1 valid", 32'(rsp_valid_v[0]), 32'd1);
        check("b2b r1 inst", rsp_inst_v[0], 32'h2222_2222);
        step();
        req_valid[0] = 1'b0;
        check("b2b gap1", 32'(rsp_valid_v[0]), 32'd0);
        step();
        check("b2b r2 valid", 32'(rsp_valid_v[0]), 32'd1);
        check("b2b r2 inst", rsp_inst_v[0], 32'h3333_3333);
        step();
        rsp_ready[0] = 1'b0;
        fcnt_e[0] = fcnt_e[0] + 32'd3;
        check("b2b fetch_cnt", fetch_cnt_v[0], fcnt_e[0]);
        check("b2b idle", 32'(rsp_valid_v[0]), 32'd0);

        // Backpressure: held response, competing request must wait.
        req_valid[0] = 1'b1; req_addr[0] = BASE + 32'd8;
        step();
        req_addr[0] = BASE + 32'd12;
        r = 0;
        while (rsp_valid_v[0] !== 1'b1 && r < 20) begin step(); r++; end
        for (int i = 0; i < 5; i++) begin
            check("bp ctrl {valid,err,req_ready}",
                  32'({rsp_valid_v[0], rsp_err_v[0], req_ready_v[0]}), 32'b100);
            check("bp inst", rsp_inst_v[0], 32'h3333_3333);
            step();
        end
        req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
        step();
        rsp_ready[0] = 1'b0;
        fcnt_e[0] = fcnt_e[0] + 32'd1;
        check("bp fetch_cnt", fetch_cnt_v[0], fcnt_e[0]);
        check("bp released", 32'(rsp_valid_v[0]), 32'd0);

        // Same-cycle loader write and accept: read-before-write.
        load(BASE + 32'h10, 32'hAAAA_AAAA);
        fetch(0, BASE + 32'h10, 32'hAAAA_AAAA, 1'b0, "hazard_old", 1'b1, BASE + 32'h10, 32'hDEAD_BEEF);
        fetch(0, BASE + 32'h10, 32'hDEAD_BEEF, 1'b0, "hazard_new", 1'b0, '0, '0);

        // Reset during WAIT discards the request.
        req_valid[0] = 1'b1; req_addr[0] = BASE;
        step();
        req_valid[0] = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        fcnt_e[0] = 0; fcnt_e[1] = 0;
        check("rstmid rsp_valid", 32'(rsp_valid_v[0]), 32'd0);
        check("rstmid fetch_cnt", fetch_cnt_v[0], 32'd0);
        check("rstmid req_ready", 32'(req_ready_v[0]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rstmid no stale rsp", 32'(rsp_valid_v[0]), 32'd0);
        end

        // LATENCY=1 instance: response on the edge after accept, and reset in RESP.
        fetch(1, BASE + 32'd4, 32'h2222_2222, 1'b0, "l1_fetch", 1'b0, '0, '0);
        req_valid[1] = 1'b1; req_addr[1] = BASE + 32'd8;
        step();
        req_valid[1] = 1'b0;
        check("l1 valid after accept", 32'(rsp_valid_v[1]), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        fcnt_e[0] = 0; fcnt_e[1] = 0;
        check("l1 rstmid rsp_valid", 32'(rsp_valid_v[1]), 32'd0);
        check("l1 rstmid fetch_cnt", fetch_cnt_v[1], 32'd0);
        check("l1 rstmid req_ready", 32'(req_ready_v[1]), 32'd1);
        fetch(1, BASE + 32'd8, 32'h3333_3333, 1'b0, "l1_after_rst", 1'b0, '0, '0);

        // Randomized run on the LATENCY=2 instance against the reference model.
        for (int i = 0; i < 32; i++) load(BASE + 32'(4 * i), $urandom);
        pend = 1'b0; due = 0; cyc = 0; e_inst = '0; e_err = 1'b0;
        for (int k = 0; k < 500; k++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       req_addr[0] = BASE + 32'(4 * $urandom_range(0, 31));
            else if (r == 8) req_addr[0] = BASE + 32'($urandom_range(0, 127));
            else             req_addr[0] = ($urandom_range(0, 1) == 0) ? BASE - 32'd4 : BASE + 32'h1000;
            req_valid[0] = ($urandom_range(0, 3) != 0);
            rsp_ready[0] = ($urandom_range(0, 2) != 0);
            ld_wen  = ($urandom_range(0, 3) == 0);
            ld_addr = ($urandom_range(0, 7) == 0) ? BASE + 32'h1000 + 32'($urandom_range(0, 15))
                                                  : BASE + 32'($urandom_range(0, 127));
            ld_data = $urandom;
            #1;
            exp_v   = pend && (cyc >= due);
            exp_rdy = !pend || (exp_v && rsp_ready[0]);
            check("rnd req_ready", 32'(req_ready_v[0]), 32'(exp_rdy));
            check("rnd rsp_valid", 32'(rsp_valid_v[0]), 32'(exp_v));
            if (exp_v) begin
                check("rnd rsp_inst", rsp_inst_v[0], e_inst);
                check("rnd rsp_err", 32'(rsp_err_v[0]), 32'(e_err));
            end
            check("rnd fetch_cnt", fetch_cnt_v[0], fcnt_e[0]);
            if (exp_v && rsp_ready[0]) begin
                fcnt_e[0] = fcnt_e[0] + 32'd1;
                pend = 1'b0;
            end
            if (req_valid[0] && exp_rdy) begin
                e_err  = mdl_err(req_addr[0]);
                e_inst = e_err ? 32'd0 : mem_m[req_addr[0][11:2]];
                pend   = 1'b1;
                due    = cyc + LAT0;
            end
            if (ld_wen) mdl_write(ld_addr, ld_data);
            step();
            cyc++;
        end
        req_valid = '0; rsp_ready = '0; ld_wen = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
